grad_update: RTL and testbench
==============================

Name: grad_update

Overview:
Backward-path companion to the squared-error loss stage. It consumes the same (predicted, target) pairs plus the input feature that produced each prediction, and computes the error gradient. It accumulates weight and bias gradients over a mini-batch, then applies one shift-scaled, saturating weight/bias update. It sits between the loss/prediction stage and the weight registers of the single-neuron datapath.

Parameters:
W_W, 16, signed weight/bias width (two's complement)
BATCH_LOG2, 2, log2 of samples per batch (batch = 4)
LR_SHIFT, 2, learning rate = 2^-LR_SHIFT
W_INIT, 0, reset/initial value of weight_o
B_INIT, 0, reset/initial value of bias_o

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  sample present
ready_o  out  1  block can accept a sample
target_i  in  4  unsigned target
predicted_i  in  21  unsigned prediction
x_i  in  4  unsigned input feature for this sample
clear_i  in  1  synchronous batch abort; does not touch weights
weight_o  out  W_W  current signed weight
bias_o  out  W_W  current signed bias
update_valid_o  out  1  one-cycle pulse when new weight/bias are visible
count_o  out  BATCH_LOG2  samples accepted in current batch

Behaviour:
- Reset (rst_i=0, async): state=ACCUM, acc_w=0, acc_b=0, count_o=0, weight_o=W_INIT, bias_o=B_INIT, update_valid_o=0, ready_o=1.
- Accept: a sample is taken on the rising edge when valid_i && ready_o.
- ready_o=1 in ACCUM and 0 in APPLY. It is registered or state-decoded with no combinational path from valid_i.
- Arithmetic:
  - e = {1'b0,predicted_i} - {18'b0,target_i}, 22-bit signed.
  - g = e * {1'b0,x_i}, 27-bit signed.
  - acc_w has width 27+BATCH_LOG2; acc_b has width 22+BATCH_LOG2. Both are signed and wide enough that they never overflow.
- ACCUM state:
  - On accept: acc_w += g, acc_b += e, count_o increments.
  - If the accepted sample is the 2^BATCH_LOG2-th: next state=APPLY, and count_o wraps to 0.
- APPLY state (exactly one cycle):
  - delta_w = acc_w >>> (LR_SHIFT+BATCH_LOG2), an arithmetic shift that floors toward -inf. delta_b is formed the same way from acc_b.
  - weight_o <= sat(weight_o - delta_w) and bias_o <= sat(bias_o - delta_b). The subtraction is done at full width, then saturated to [-2^(W_W-1), 2^(W_W-1)-1].
  - acc_w and acc_b clear; update_valid_o <= 1; next state=ACCUM.
- Latency: last sample accepted at edge N. weight_o/bias_o change and update_valid_o=1 after edge N+1. update_valid_o returns to 0 after edge N+2. ready_o is low only between edges N and N+1.
- update_valid_o is 0 in every cycle other than the one following APPLY.
- valid_i while ready_o=0 is ignored; it is not counted or accumulated, and the upstream stage must hold or retry the sample.
- clear_i in ACCUM:
  - acc_w, acc_b and count_o clear; weights unchanged.
  - Takes priority over a simultaneous accept; that sample is dropped.
- clear_i in APPLY: ignored; the update completes.
- Reset mid-batch or mid-APPLY: all state returns to reset values immediately; no partial update survives.
- Saturation is sticky only in value: further updates continue from the saturated weight.

Test Plan:
- Reset check: assert rst_i=0 mid-run -> weight_o=0, bias_o=0, count_o=0, ready_o=1, update_valid_o=0, with no clock edge needed.
- Positive error batch: 4 samples of pred=10, tgt=2, x=3 (e=8, g=24; acc_w=96, acc_b=32; shift 4) -> one cycle after the 4th accept, weight_o=-6, bias_o=-2, update_valid_o high for exactly 1 cycle, ready_o low for 1 cycle.
- Negative error with floor: 4 samples of pred=0, tgt=15, x=15 (acc_w=-900, acc_b=-60) -> weight_o=+57, bias_o=+4, confirming -56.25 floors to -57 and -3.75 floors to -4.
- Saturation: 4 samples of pred=2097151, tgt=0, x=15 -> weight_o=-32768, bias_o=-32768. A second identical batch leaves both at -32768 without wrapping to positive.
- Handshake stall: hold valid_i=1 across APPLY with a 5th sample -> the sample is not accepted during APPLY, is accepted the following cycle, and count_o=1.
- Abort and reset mid-batch: after 2 accepts, pulse clear_i together with valid_i -> count_o=0, weights unchanged, and that sample is dropped. Then 2 accepts followed by rst_i=0 -> all outputs return to W_INIT/B_INIT/0 and no update_valid_o pulse occurs.

Source files
------------

// File: rtl/grad_update.sv
// Squared-error gradient accumulator: sums weight/bias gradients over a
// mini-batch, then applies one shift-scaled, saturating update.
//
// state | meaning
// ACCUM | accepting samples, accumulating gradients
// APPLY | one cycle: apply scaled update to weight/bias, clear accumulators
module grad_update #(
    parameter int W_W        = 16,
    parameter int BATCH_LOG2 = 2,
    parameter int LR_SHIFT   = 2,
    parameter int W_INIT     = 0,
    parameter int B_INIT     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            target_i,
    input  logic [20:0]           predicted_i,
    input  logic [3:0]            x_i,
    input  logic                  clear_i,
    output logic [W_W-1:0]        weight_o,
    output logic [W_W-1:0]        bias_o,
    output logic                  update_valid_o,
    output logic [BATCH_LOG2-1:0] count_o
);

    localparam int AW    = 27 + BATCH_LOG2;
    localparam int BW    = 22 + BATCH_LOG2;
    localparam int SHIFT = LR_SHIFT + BATCH_LOG2;
    localparam int WDW   = ((AW > W_W) ? AW : W_W) + 1;
    localparam int WDB   = ((BW > W_W) ? BW : W_W) + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_w_q;
    logic signed [BW-1:0]    acc_b_q;
    logic [BATCH_LOG2-1:0]   count_q;
    logic signed [W_W-1:0]   weight_q, bias_q;
    logic                    upd_q;

    logic                    accept;
    logic signed [21:0]      err;
    logic signed [26:0]      grad;
    logic signed [AW-1:0]    delta_w;
    logic signed [BW-1:0]    delta_b;
    logic signed [WDW-1:0]   diff_w;
    logic signed [WDB-1:0]   diff_b;
    logic signed [W_W-1:0]   sat_w, sat_b;

    assign ready_o        = (state_q == ACCUM);
    assign accept         = valid_i && ready_o;
    assign weight_o       = weight_q;
    assign bias_o         = bias_q;
    assign update_valid_o = upd_q;
    assign count_o        = count_q;

    assign err     = $signed({1'b0, predicted_i}) - $signed({18'b0, target_i});
    assign grad    = 27'(err) * 27'($signed({1'b0, x_i}));
    assign delta_w = acc_w_q >>> SHIFT;
    assign delta_b = acc_b_q >>> SHIFT;
    assign diff_w  = WDW'(weight_q) - WDW'(delta_w);
    assign diff_b  = WDB'(bias_q) - WDB'(delta_b);

    // In range only when all bits above the result sign bit match it
    always_comb begin
        sat_w = diff_w[W_W-1:0];
        if (diff_w[WDW-1:W_W-1] != {(WDW-W_W+1){diff_w[WDW-1]}})
            sat_w = diff_w[WDW-1] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
    end

    always_comb begin
        sat_b = diff_b[W_W-1:0];
        if (diff_b[WDB-1:W_W-1] != {(WDB-W_W+1){diff_b[WDB-1]}})
            sat_b = diff_b[WDB-1] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (!clear_i && accept && (count_q == '1)) state_d = APPLY;
            APPLY: state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ACCUM;
            acc_w_q  <= '0;
            acc_b_q  <= '0;
            count_q  <= '0;
            weight_q <= W_W'(W_INIT);
            bias_q   <= W_W'(B_INIT);
            upd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_q   <= 1'b0;
            case (state_q)
                ACCUM: begin
                    if (clear_i) begin
                        acc_w_q <= '0;
                        acc_b_q <= '0;
                        count_q <= '0;
                    end else if (accept) begin
                        acc_w_q <= acc_w_q + AW'(grad);
                        acc_b_q <= acc_b_q + BW'(err);
                        count_q <= count_q + 1'b1;
                    end
                end
                APPLY: begin
                    weight_q <= sat_w;
                    bias_q   <= sat_b;
                    acc_w_q  <= '0;
                    acc_b_q  <= '0;
                    upd_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grad_update.sv
// Scoreboard bench for grad_update: directed batches push expected
// weight/bias; a monitor compares on every update_valid_o pulse.
module tb_grad_update;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               valid_i = 1'b0;
    logic               clear_i = 1'b0;
    logic [3:0]         target_i = '0;
    logic [20:0]        predicted_i = '0;
    logic [3:0]         x_i = '0;
    logic               ready_o;
    logic signed [15:0] weight_o;
    logic signed [15:0] bias_o;
    logic               update_valid_o;
    logic [1:0]         count_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ev;

    grad_update dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .target_i       (target_i),
        .predicted_i    (predicted_i),
        .x_i            (x_i),
        .clear_i        (clear_i),
        .weight_o       (weight_o),
        .bias_o         (bias_o),
        .update_valid_o (update_valid_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (update_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_update", 1, 0);
            end else begin
                ev = exp_q.pop_front();
                check("weight", weight_o, $signed(ev[31:16]));
                check("bias", bias_o, $signed(ev[15:0]));
            end
        end
    end

    task automatic send(input logic [20:0] p, input logic [3:0] t, input logic [3:0] x);
        @(negedge clk_i);
        predicted_i = p;
        target_i    = t;
        x_i         = x;
        valid_i     = 1'b1;
        check("ready_before_accept", ready_o, 1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_weight"}, weight_o, 0);
        check({tag, "_bias"}, bias_o, 0);
        check({tag, "_count"}, count_o, 0);
        check({tag, "_ready"}, ready_o, 1);
        check({tag, "_upd"}, update_valid_o, 0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1 check_reset_outputs(tag);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic batch(input logic [20:0] p, input logic [3:0] t, input logic [3:0] x,
                         input logic [15:0] w_exp, input logic [15:0] b_exp,
                         input bit clr_in_apply);
        exp_q.push_back({w_exp, b_exp});
        repeat (3) send(p, t, x);
        check("count_after_3", count_o, 3);
        send(p, t, x);
        check("ready_in_apply", ready_o, 0);
        check("upd_in_apply", update_valid_o, 0);
        check("count_wrap", count_o, 0);
        if (clr_in_apply) clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
        check("upd_pulse", update_valid_o, 1);
        check("ready_after_apply", ready_o, 1);
        @(posedge clk_i);
        #1 check("upd_pulse_end", update_valid_o, 0);
    endtask

    initial begin
        #12 check_reset_outputs("initial_reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // positive error: acc_w=96, acc_b=32 -> -6 / -2
        batch(21'd10, 4'd2, 4'd3, -16'sd6, -16'sd2, 1'b0);

        // reset mid-batch after non-zero weights
        send(21'd10, 4'd2, 4'd3);
        send(21'd10, 4'd2, 4'd3);
        check("count_mid", count_o, 2);
        async_reset("reset_mid");

        // negative error with floor; clear_i during APPLY ignored
        batch(21'd0, 4'd15, 4'd15, 16'sd57, 16'sd4, 1'b1);

        // saturation, twice
        async_reset("reset_sat");
        batch(21'd2097151, 4'd0, 4'd15, 16'h8000, 16'h8000, 1'b0);
        batch(21'd2097151, 4'd0, 4'd15, 16'h8000, 16'h8000, 1'b0);

        // stall: 5th sample held across APPLY, accepted next cycle
        async_reset("reset_stall");
        exp_q.push_back({-16'sd6, -16'sd2});
        repeat (4) send(21'd10, 4'd2, 4'd3);
        valid_i = 1'b1;
        check("stall_ready_low", ready_o, 0);
        @(posedge clk_i);
        #1 check("stall_not_taken", count_o, 0);
        check("stall_upd", update_valid_o, 1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        check("stall_taken", count_o, 1);
        exp_q.push_back({-16'sd12, -16'sd4});
        repeat (3) send(21'd10, 4'd2, 4'd3);
        @(posedge clk_i);
        #1 check("stall_batch_upd", update_valid_o, 1);
        @(posedge clk_i);

        // clear with simultaneous valid drops the sample and the partial batch
        async_reset("reset_clear");
        send(21'd0, 4'd15, 4'd15);
        send(21'd0, 4'd15, 4'd15);
        check("clear_pre_count", count_o, 2);
        @(negedge clk_i);
        clear_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
        valid_i = 1'b0;
        check("clear_count", count_o, 0);
        check("clear_weight", weight_o, 0);
        check("clear_bias", bias_o, 0);
        check("clear_upd", update_valid_o, 0);
        batch(21'd10, 4'd2, 4'd3, -16'sd6, -16'sd2, 1'b0);

        // 2 accepts then reset: no update pulse may appear
        send(21'd10, 4'd2, 4'd3);
        send(21'd10, 4'd2, 4'd3);
        check("pre_reset_count", count_o, 2);
        async_reset("reset_final");
        repeat (6) @(negedge clk_i);
        check_reset_outputs("post_reset_idle");

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
